// File: rtl/brom_ctrl.sv
// Boot ROM overlay controller: serves 0x0000-0x00FF from the boot ROM while mapped,
// owns the sticky 0xFF50 unmap register and forwards everything else to the external bus.
module brom_ctrl #(
  parameter int          EXT_TIMEOUT = 16,
  parameter logic [7:0]  OPEN_BUS    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ready,
  output logic [7:0]  brom_a,
  input  logic [7:0]  brom_d,
  output logic [15:0] ext_a,
  output logic [7:0]  ext_dout,
  output logic        ext_rd,
  output logic        ext_wr,
  input  logic [7:0]  ext_din,
  input  logic        ext_ack,
  output logic        brom_en
);

  localparam int CNT_W = $clog2(EXT_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [15:0] DISABLE_REG = 16'hFF50;

  typedef enum logic [1:0] {IDLE, EXT, DONE} state_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]      cpu_dout_nxt, ext_dout_nxt;
  logic [15:0]     ext_a_nxt;
  logic            cpu_ready_nxt, ext_rd_nxt, ext_wr_nxt, brom_en_nxt;

  assign brom_a = cpu_a[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cpu_dout  <= 8'h00;
      cpu_ready <= 1'b0;
      ext_a     <= 16'h0000;
      ext_dout  <= 8'h00;
      ext_rd    <= 1'b0;
      ext_wr    <= 1'b0;
      brom_en   <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cpu_dout  <= cpu_dout_nxt;
      cpu_ready <= cpu_ready_nxt;
      ext_a     <= ext_a_nxt;
      ext_dout  <= ext_dout_nxt;
      ext_rd    <= ext_rd_nxt;
      ext_wr    <= ext_wr_nxt;
      brom_en   <= brom_en_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cpu_dout_nxt  = cpu_dout;
    cpu_ready_nxt = 1'b0;
    ext_a_nxt     = ext_a;
    ext_dout_nxt  = ext_dout;
    ext_rd_nxt    = ext_rd;
    ext_wr_nxt    = ext_wr;
    brom_en_nxt   = brom_en;
    unique case (state)
      IDLE: begin
        // A simultaneous rd+wr is resolved as a read.
        if (!cpu_ready && (cpu_rd || cpu_wr)) begin
          if (cpu_rd && brom_en && (cpu_a <= 16'h00FF)) begin
            cpu_dout_nxt  = brom_d;
            cpu_ready_nxt = 1'b1;
            state_nxt     = DONE;
          end else if (cpu_a == DISABLE_REG) begin
            if (cpu_rd)
              cpu_dout_nxt = OPEN_BUS;
            else if (cpu_din[0])
              brom_en_nxt = 1'b0;
            cpu_ready_nxt = 1'b1;
            state_nxt     = DONE;
          end else begin
            ext_a_nxt    = cpu_a;
            ext_dout_nxt = cpu_din;
            ext_rd_nxt   = cpu_rd;
            ext_wr_nxt   = !cpu_rd;
            cnt_nxt      = '0;
            state_nxt    = EXT;
          end
        end
      end
      EXT: begin
        if (ext_ack) begin
          if (ext_rd)
            cpu_dout_nxt = ext_din;
          ext_rd_nxt    = 1'b0;
          ext_wr_nxt    = 1'b0;
          cpu_ready_nxt = 1'b1;
          state_nxt     = DONE;
        end else if (cnt == CNT_LAST) begin
          if (ext_rd)
            cpu_dout_nxt = OPEN_BUS;
          ext_rd_nxt    = 1'b0;
          ext_wr_nxt    = 1'b0;
          cpu_ready_nxt = 1'b1;
          state_nxt     = DONE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_brom_ctrl.sv
// Directed bench for brom_ctrl: boot ROM reads, external handshake, timeout,
// the sticky 0xFF50 unmap register and asynchronous reset mid-transfer.
module tb_brom_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_a = '0;
  logic [7:0]  cpu_din = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_dout;
  logic        cpu_ready;
  logic [7:0]  brom_a;
  logic [7:0]  brom_d;
  logic [15:0] ext_a;
  logic [7:0]  ext_dout;
  logic        ext_rd;
  logic        ext_wr;
  logic [7:0]  ext_din = '0;
  logic        ext_ack = 1'b0;
  logic        brom_en;

  int testsRun = 0;
  int testsFailed = 0;

  brom_ctrl #(.EXT_TIMEOUT(16), .OPEN_BUS(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
    .brom_a(brom_a), .brom_d(brom_d),
    .ext_a(ext_a), .ext_dout(ext_dout), .ext_rd(ext_rd), .ext_wr(ext_wr),
    .ext_din(ext_din), .ext_ack(ext_ack), .brom_en(brom_en)
  );

  always #5 clk = ~clk;

  // Boot ROM image: first byte 0x31, last byte 0x50, filler elsewhere.
  assign brom_d = (brom_a == 8'h00) ? 8'h31 :
                  (brom_a == 8'hFF) ? 8'h50 : (brom_a ^ 8'h5A);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Runs one CPU access and plays the external slave; ackDelay<0 means never ack.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] din,
                               input logic rd, input logic wr,
                               input int ackDelay, input logic [7:0] ackData,
                               output logic [7:0] dout, output int latency,
                               output int strobeCycles, output logic [15:0] seenA,
                               output logic [7:0] seenD, output logic seenWr,
                               output logic strobeAtReady);
    cpu_a = addr; cpu_din = din; cpu_rd = rd; cpu_wr = wr;
    latency = -1; strobeCycles = 0; seenA = '0; seenD = '0; seenWr = 1'b0;
    dout = '0; strobeAtReady = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin
        latency = n;
        dout = cpu_dout;
        strobeAtReady = ext_rd | ext_wr;
        break;
      end
      if (ext_rd || ext_wr) begin
        if (strobeCycles == 0) begin
          seenA = ext_a; seenD = ext_dout; seenWr = ext_wr;
        end
        strobeCycles++;
        if (ackDelay >= 0 && strobeCycles == ackDelay) begin
          ext_ack = 1'b1; ext_din = ackData;
        end else begin
          ext_ack = 1'b0;
        end
      end
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0; ext_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0]  dout, seenD;
  logic [15:0] seenA;
  logic        seenWr, strobeAtReady;
  int          latency, strobes;

  initial begin
    #12;
    checkOutput("reset_cpu_ready", cpu_ready, 0);
    checkOutput("reset_cpu_dout", cpu_dout, 8'h00);
    checkOutput("reset_ext_rd", ext_rd, 0);
    checkOutput("reset_ext_wr", ext_wr, 0);
    checkOutput("reset_ext_a", ext_a, 0);
    checkOutput("reset_brom_en", brom_en, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Boot ROM reads
    applyStimulus(16'h0000, 8'h00, 1, 0, -1, 8'h00, dout, latency, strobes, seenA, seenD, seenWr, strobeAtReady);
    checkOutput("rom0_dout", dout, 8'h31);
    checkOutput("rom0_latency", latency, 1);
    checkOutput("rom0_no_ext", strobes, 0);
    applyStimulus(16'h00FF, 8'h00, 1, 1, -1, 8'h00, dout, latency, strobes, seenA, seenD, seenWr, strobeAtReady);
    checkOutput("romFF_rdwr_dout", dout, 8'h50);
    checkOutput("romFF_latency", latency, 1);
    checkOutput("romFF_no_ext", strobes, 0);

    // External read acked on the third strobe cycle
    applyStimulus(16'h0100, 8'h00, 1, 0, 3, 8'hC3, dout, latency, strobes, seenA, seenD, seenWr, strobeAtReady);
    checkOutput("ext_rd_dout", dout, 8'hC3);
    checkOutput("ext_rd_strobes", strobes, 3);
    checkOutput("ext_rd_latency", latency, 4);
    checkOutput("ext_rd_addr", seenA, 16'h0100);
    checkOutput("ext_rd_dropped", strobeAtReady, 0);

    // Write into ROM window goes external, output data untouched
    applyStimulus(16'h0050, 8'h0A, 0, 1, 1, 8'h00, dout, latency, strobes, seenA, seenD, seenWr, strobeAtReady);
    checkOutput("mbc_wr_is_wr", seenWr, 1);
    checkOutput("mbc_wr_addr", seenA, 16'h0050);
    checkOutput("mbc_wr_data", seenD, 8'h0A);
    checkOutput("mbc_wr_dout_kept", dout, 8'hC3);
    checkOutput("mbc_wr_brom_en", brom_en, 1);

    // 0xFF50 register
    applyStimulus(16'hFF50, 8'h00, 1, 0, -1, 8'h00, dout, latency, strobes, seenA, seenD, seenWr, strobeAtReady);
    checkOutput("ff50_rd_open_bus", dout, 8'hFF);
    checkOutput("ff50_rd_no_ext", strobes, 0);
    applyStimulus(16'hFF50, 8'h00, 0, 1, -1, 8'h00, dout, latency, strobes, seenA, seenD, seenWr, strobeAtReady);
    checkOutput("ff50_wr0_latency", latency, 1);
    checkOutput("ff50_wr0_brom_en", brom_en, 1);
    cpu_a = 16'hFF50; cpu_din = 8'h01; cpu_wr = 1'b1;
    @(posedge clk); #1;
    checkOutput("ff50_wr1_ready", cpu_ready, 1);
    checkOutput("ff50_wr1_brom_en", brom_en, 0);
    cpu_wr = 1'b0;
    @(posedge clk); #1;
    applyStimulus(16'h0000, 8'h00, 1, 0, 2, 8'hAA, dout, latency, strobes, seenA, seenD, seenWr, strobeAtReady);
    checkOutput("unmapped_rd_dout", dout, 8'hAA);
    checkOutput("unmapped_rd_strobes", strobes, 2);
    applyStimulus(16'hFF50, 8'h00, 0, 1, -1, 8'h00, dout, latency, strobes, seenA, seenD, seenWr, strobeAtReady);
    checkOutput("ff50_sticky", brom_en, 0);

    // Timeout
    applyStimulus(16'h4000, 8'h00, 1, 0, -1, 8'h00, dout, latency, strobes, seenA, seenD, seenWr, strobeAtReady);
    checkOutput("timeout_strobes", strobes, 16);
    checkOutput("timeout_latency", latency, 17);
    checkOutput("timeout_dout", dout, 8'hFF);
    checkOutput("timeout_dropped", strobeAtReady, 0);

    // Reset mid-transfer
    cpu_a = 16'h4000; cpu_rd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_reset_ext_rd", ext_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_ext_rd", ext_rd, 0);
    checkOutput("async_ready", cpu_ready, 0);
    checkOutput("async_brom_en", brom_en, 1);
    cpu_rd = 1'b0;
    @(posedge clk); #1;
    checkOutput("in_reset_ready", cpu_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(16'h0000, 8'h00, 1, 0, -1, 8'h00, dout, latency, strobes, seenA, seenD, seenWr, strobeAtReady);
    checkOutput("post_reset_rom0", dout, 8'h31);
    checkOutput("post_reset_no_ext", strobes, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
